// File: rtl/i_cache_dm_if.sv
// Refill bus between i_cache_dm and instruction memory.
// master: cache side (drives mem_req/mem_addr); slave: memory side (drives gnt/rvalid/rdata).
interface i_cache_dm_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache with beat-by-beat line refill, flush,
// address-range protection (sticky seg fault) and atomic flagging.
// Ports: clk, rst_n (async, active-low); fetch side rd_en, cur_pc, flush ->
// ins, ins_valid, i_miss, atomic, i_cache_seg_fault; refill bus via mem
// (i_cache_dm_if.master). Optional ICACHE_PERF_EN adds hit_cnt/miss_cnt.
module i_cache_dm #(
    parameter int                ADDR_W     = 32,
    parameter int                NUM_LINES  = 64,
    parameter int                LINE_WORDS = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h0001_0000),
    parameter logic [ADDR_W-1:0] LIMIT_ADDR = ADDR_W'(32'h0001_FFFF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] cur_pc,
    input  logic              flush,
    output logic [31:0]       ins,
    output logic              ins_valid,
    output logic              i_miss,
    output logic              atomic,
    output logic              i_cache_seg_fault,
`ifdef ICACHE_PERF_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
`endif
    i_cache_dm_if.master      mem
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int DEPTH = NUM_LINES * LINE_WORDS;

    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [31:0]          r_data [DEPTH];

    logic [TAG_W-1:0]  r_f_tag;
    logic [IDX_W-1:0]  r_f_idx;
    logic [OFF_W-1:0]  r_f_off;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [OFF_W-1:0]  r_beat;
    logic              r_flush_pend;
    logic              r_seg;
    logic [31:0]       r_ins;
    logic              r_ins_valid;

    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;
    logic             w_idle;
    logic             w_fault;
    logic             w_lookup;
    logic             w_hit;
    logic             w_miss;
    logic             w_beat;
    logic             w_beat_last;
    logic             w_flush_now;
    logic [31:0]      w_fill_word;

    assign w_tag = cur_pc[ADDR_W-1 -: TAG_W];
    assign w_idx = cur_pc[OFF_W+2 +: IDX_W];
    assign w_off = cur_pc[2 +: OFF_W];

    assign w_idle  = (r_state == IDLE);
    assign w_fault = rd_en && w_idle &&
                     ((cur_pc < BASE_ADDR) ||
                      (cur_pc > LIMIT_ADDR) ||
                      (cur_pc[1:0] != 2'b00));

    assign w_lookup = rd_en && w_idle && !w_fault;
    assign w_hit    = w_lookup && r_valid[w_idx] &&
                      (r_tag[w_idx] == w_tag);
    assign w_miss   = w_lookup && !w_hit;

    assign w_beat      = (r_state == FILL) && mem.mem_rvalid;
    assign w_beat_last = w_beat && (r_beat == LAST);

    // A flush seen mid-refill is deferred to the RESP->IDLE edge so the
    // line that was just filled is invalidated together with the rest.
    assign w_flush_now = (w_idle && flush) ||
                         ((r_state == RESP) && (flush || r_flush_pend));

    // The requested word is the beat arriving right now when it is the
    // last one; every earlier word is already in the array.
    assign w_fill_word = (r_f_off == LAST) ? mem.mem_rdata
                                           : r_data[{r_f_idx, r_f_off}];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_miss) w_next = REQ;
            REQ:  if (mem.mem_gnt) w_next = FILL;
            FILL: if (w_beat_last) w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_f_tag      <= '0;
            r_f_idx      <= '0;
            r_f_off      <= '0;
            r_mem_addr   <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_seg        <= 1'b0;
            r_ins        <= '0;
            r_ins_valid  <= 1'b0;
        end else begin
            r_ins_valid <= 1'b0;

            if (w_fault) r_seg <= 1'b1;

            if (w_hit) begin
                r_ins       <= r_data[{w_idx, w_off}];
                r_ins_valid <= 1'b1;
            end

            if (w_miss) begin
                r_f_tag    <= w_tag;
                r_f_idx    <= w_idx;
                r_f_off    <= w_off;
                r_mem_addr <= {cur_pc[ADDR_W-1:OFF_W+2],
                               {(OFF_W+2){1'b0}}};
            end

            if (w_beat) r_beat <= r_beat + OFF_W'(1);

            if (w_beat_last) begin
                r_beat           <= '0;
                r_valid[r_f_idx] <= 1'b1;
                r_ins            <= w_fill_word;
                r_ins_valid      <= 1'b1;
            end

            if (((r_state == REQ) || (r_state == FILL)) && flush)
                r_flush_pend <= 1'b1;

            if (w_flush_now) begin
                r_valid      <= '0;
                r_flush_pend <= 1'b0;
            end
        end
    end

    // Tag/data arrays are plain storage; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_beat) r_data[{r_f_idx, r_beat}] <= mem.mem_rdata;
        if (w_beat_last) r_tag[r_f_idx] <= r_f_tag;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_hit) begin
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
        end else if (w_miss) begin
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign ins               = r_ins;
    assign ins_valid         = r_ins_valid;
    assign atomic            = r_ins[0] & r_ins_valid;
    assign i_miss            = !w_idle;
    assign i_cache_seg_fault = r_seg;
    assign mem.mem_req       = (r_state == REQ);
    assign mem.mem_addr      = r_mem_addr;

endmodule
